// File: rtl/fibonacci_lanes.sv
// -----------------------------------------------------------------------------
// fibonacci_lanes
//   Fibonacci sequence source. Each accepted beat carries LANES consecutive
//   terms of WIDTH bits. A load pulse restarts the sequence from a seed pair.
//   The output side uses valid/ready backpressure. A running index reports the
//   position of lane 0. Overflow is handled by wrapping (MODE 0), saturating
//   (MODE 1) or halting (MODE 2).
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   load         : synchronous seed load / restart pulse (beats handshake)
//   seed_a       : first term of the new sequence (index 0)
//   seed_b       : second term of the new sequence (index 1)
//   out_valid    : out_data holds a valid beat
//   out_ready    : downstream accepts the beat
//   out_data     : lane k at [k*WIDTH +: WIDTH], lane 0 = earliest term
//   out_index    : sequence index of lane 0
//   out_overflow : sticky flag, some presented term exceeded 2^WIDTH-1
// -----------------------------------------------------------------------------
module fibonacci_lanes #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int IDX_W = 16,
    parameter int MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH-1:0]       seed_a,
    input  logic [WIDTH-1:0]       seed_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_valid;
    logic [LANES*WIDTH-1:0] r_data;
    logic [IDX_W-1:0]       r_index;
    logic                   r_ovf;

    // History holds the next two terms still to be presented (lane 0 and
    // lane 1 of the next beat), each with a cumulative overflow flag. Keeping
    // the *upcoming* pair rather than the last pair presented lets LANES=1
    // park seed_b here without any special case.
    logic [WIDTH-1:0]       r_next_a;
    logic [WIDTH-1:0]       r_next_b;
    logic                   r_next_a_ovf;
    logic                   r_next_b_ovf;

    // Term chain: entries 0..LANES-1 form the beat, entries LANES and LANES+1
    // become the new history. w_cum[k] = term k or any earlier term overflowed.
    logic [WIDTH-1:0]       w_term [LANES+2];
    logic                   w_cum  [LANES+2];
    logic [WIDTH:0]         w_sum;
    logic [LANES*WIDTH-1:0] w_beat;
    logic                   w_beat_ovf;
    logic                   w_advance;

    always_comb begin
        for (int k = 0; k < LANES + 2; k++) begin
            w_term[k] = '0;
            w_cum[k]  = 1'b0;
        end
        w_sum = '0;

        w_term[0] = load ? seed_a : r_next_a;
        w_term[1] = load ? seed_b : r_next_b;
        w_cum[0]  = load ? 1'b0   : r_next_a_ovf;
        w_cum[1]  = load ? 1'b0   : r_next_b_ovf;

        for (int k = 2; k < LANES + 2; k++) begin
            w_sum    = {1'b0, w_term[k-1]} + {1'b0, w_term[k-2]};
            w_cum[k] = w_cum[k-1] | w_sum[WIDTH];
            // Saturation is sticky along the chain: once any term has
            // overflowed, every later term is forced to all-ones.
            if (MODE == 1 && w_cum[k]) begin
                w_term[k] = '1;
            end else begin
                w_term[k] = w_sum[WIDTH-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_pack
            assign w_beat[gi*WIDTH +: WIDTH] = w_term[gi];
        end
    endgenerate

    // Flags are cumulative, so the last lane summarises the whole beat.
    assign w_beat_ovf = w_cum[LANES-1];
    assign w_advance  = (r_state == S_RUN) && r_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_index      <= '0;
            r_ovf        <= 1'b0;
            r_next_a     <= '0;
            r_next_b     <= '0;
            r_next_a_ovf <= 1'b0;
            r_next_b_ovf <= 1'b0;
        end else if (load) begin
            r_index <= '0;
            if (MODE == 2 && w_beat_ovf) begin
                // Seeds overflow inside the very first beat: nothing is ever
                // presented for this sequence.
                r_state <= S_DONE;
                r_valid <= 1'b0;
                r_ovf   <= 1'b1;
                r_data  <= '0;
            end else begin
                r_state      <= S_RUN;
                r_valid      <= 1'b1;
                r_ovf        <= w_beat_ovf;
                r_data       <= w_beat;
                r_next_a     <= w_term[LANES];
                r_next_b     <= w_term[LANES+1];
                r_next_a_ovf <= w_cum[LANES];
                r_next_b_ovf <= w_cum[LANES+1];
            end
        end else if (w_advance) begin
            if (MODE == 2 && w_beat_ovf) begin
                // Halt: the offending beat is withheld; the last accepted
                // beat and its index stay on the outputs.
                r_state <= S_DONE;
                r_valid <= 1'b0;
                r_ovf   <= 1'b1;
            end else begin
                r_data       <= w_beat;
                r_index      <= r_index + IDX_W'(LANES);
                r_ovf        <= r_ovf | w_beat_ovf;
                r_next_a     <= w_term[LANES];
                r_next_b     <= w_term[LANES+1];
                r_next_a_ovf <= w_cum[LANES];
                r_next_b_ovf <= w_cum[LANES+1];
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_data     = r_data;
    assign out_index    = r_index;
    assign out_overflow = r_ovf;

endmodule

// File: doc/fibonacci_lanes.md
Name: fibonacci_lanes

Overview:
Parametrised Fibonacci sequence generator producing LANES consecutive terms per accepted beat, WIDTH bits each. Supports a loadable seed pair, valid/ready output backpressure, a running sequence index and configurable overflow handling (wrap, saturate or halt). Acts as a stimulus/data source for downstream streaming blocks in the sequential-basics set.

Parameters:
WIDTH, 16, bit width of each term (2..32)
LANES, 2, terms produced per beat (1..8)
IDX_W, 16, width of the sequence index output
MODE, 0, overflow policy: 0 = wrap modulo 2^WIDTH, 1 = saturate, 2 = halt

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  synchronous seed load / restart pulse
seed_a  input  WIDTH  first term of new sequence
seed_b  input  WIDTH  second term of new sequence
out_valid  output  1  out_data holds a valid beat
out_ready  input  1  downstream accepts beat
out_data  output  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 = earliest term
out_index  output  IDX_W  sequence index of lane 0 (seed_a = index 0)
out_overflow  output  1  sticky: some term exceeded 2^WIDTH-1

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst_n low, async) -> IDLE; out_valid=0, out_data=0, out_index=0, out_overflow=0, internal history cleared.
- IDLE: out_valid=0; handshake ignored; waits for load.
- load=1 in any state (priority over handshake): next cycle -> RUN, out_valid=1, out_index=0, out_overflow recomputed from new beat only. Lanes: lane0=seed_a, lane1=seed_b, lane k=lane(k-1)+lane(k-2). LANES=1: lane0=seed_a; seed_b kept in hidden history.
- Latency: load to first valid beat = 1 cycle. Throughput: one beat per cycle while out_ready=1.
- RUN, out_valid & out_ready: next beat presented next cycle; lane0 = sum of last two terms of previous sequence, later lanes as above; out_index += LANES (wraps mod 2^IDX_W).
- RUN, out_valid & !out_ready: out_data, out_index, out_overflow, history all held stable.
- Sums computed at WIDTH+1 bits; any term with carry = overflow event; out_overflow set in the same cycle as the beat containing it, stays set until reset or load.
- MODE 0: lanes and history truncated mod 2^WIDTH; sequence continues.
- MODE 1: overflowing lane and all later lanes = 2^WIDTH-1; all subsequent beats all-ones; index still advances.
- MODE 2: beat containing overflow is not presented; -> DONE, out_valid=0, out_overflow=1, out_data holds last accepted beat, out_index unchanged. DONE exits only via load or reset.
- Seeds producing overflow inside the first beat follow the same rules (MODE 2: straight to DONE, out_valid=0).
- rst_n asserted mid-stream: immediate return to reset values regardless of handshake.

Test Plan:
- Reset, load seeds 1,1, WIDTH=16, LANES=2, out_ready=1 -> beats (1,1),(2,3),(5,8),(13,21); out_index 0,2,4,6; out_overflow=0.
- Same, run to index 22 -> (28657,46368); MODE 0 next beat index 24 = (9489,55857), out_overflow=1; MODE 1 = (65535,65535) then all-ones; MODE 2 -> out_valid=0, DONE, out_data stays (28657,46368).
- LANES=3, seeds 0,1 -> (0,1,1),(2,3,5),(8,13,21), index 0,3,6; LANES=1 seeds 1,1 -> 1,1,2,3,5 one per beat.
- Drop out_ready for 3 cycles mid-stream -> out_data/out_index frozen, no term skipped or duplicated after release.
- load asserted during stall and in DONE -> next cycle beat restarts from new seeds, index 0, overflow cleared.
- Pulse rst_n low asynchronously between edges while valid -> outputs zero immediately, out_valid=0 until next load.
